unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle.sv | 176 +++++++++++++++++
 tb/tb_unidade_controle.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// ============================================================================
// unidade_controle
// ----------------------------------------------------------------------------
// Control unit for a memory-game round. The datapath holds a 16-entry
// sequence; each round the player makes up to 16 plays. Every play is
// registered, compared against the memory word at the current address, and
// the address counter is then advanced. A round ends in success (all 16
// plays matched), error (one play mismatched) or timeout (no play within
// TIMEOUT cycles while waiting).
//
// Moore machine: every output is decoded from the state register alone.
//
// Parameters
//   TIMEOUT    cycles allowed in ESPERA without a play (2..65535)
//
// Ports
//   clock      system clock, rising edge active
//   reset      synchronous, active-high reset
//   iniciar    level request to start a round (INICIAL / final states only)
//   jogada     one-cycle play pulse from the datapath edge detector
//   igual      datapath comparator result (memory word == registered play)
//   fimC       datapath counter terminal count (address 15)
//   zeraC      clear the datapath address counter
//   contaC     advance the datapath address counter
//   zeraR      clear the datapath play register
//   registraR  load the datapath play register
//   pronto     round finished
//   acertou    round finished with all plays correct
//   errou      round finished on a wrong play
//   timeout    round abandoned because no play arrived in time
//   db_estado  current state code, for display
// ============================================================================
module unidade_controle #(
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL     = 4'b0000,
      PREPARACAO  = 4'b0001,
      ESPERA      = 4'b0010,
      REGISTRA    = 4'b0100,
      COMPARACAO  = 4'b0101,
      PROXIMO     = 4'b0110,
      FIM_ACERTO  = 4'b1010,
      FIM_ERRO    = 4'b1110,
      FIM_TIMEOUT = 4'b1101
   } estado_t;

   // Last timer value before the waiting window expires. The timer reads 0
   // in the first ESPERA cycle, so reaching TIMEOUT-1 means TIMEOUT cycles
   // have been spent waiting.
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   estado_t     estado_q;
   estado_t     estado_d;
   logic [15:0] timer_q;
   logic [15:0] timer_d;

   // State and wait-timer registers. Reset wins over every other input,
   // including a simultaneous iniciar, and drops any round in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= INICIAL;
         timer_q  <= '0;
      end else begin
         estado_q <= estado_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state logic. Unused codes fall back to INICIAL so the machine
   // always recovers to a known state.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL: begin
            if (iniciar) estado_d = PREPARACAO;
         end
         PREPARACAO: begin
            estado_d = ESPERA;
         end
         ESPERA: begin
            // A play arriving in the last waiting cycle still counts.
            if (jogada)                    estado_d = REGISTRA;
            else if (timer_q == TIMER_LAST) estado_d = FIM_TIMEOUT;
         end
         REGISTRA: begin
            // One cycle for the play register and memory to settle before
            // igual is trusted.
            estado_d = COMPARACAO;
         end
         COMPARACAO: begin
            if (!igual)    estado_d = FIM_ERRO;
            else if (fimC) estado_d = FIM_ACERTO;
            else           estado_d = PROXIMO;
         end
         PROXIMO: begin
            estado_d = ESPERA;
         end
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (iniciar) estado_d = PREPARACAO;
         end
         default: begin
            estado_d = INICIAL;
         end
      endcase
   end

   // Wait timer. It only counts while the machine stays in ESPERA, and reads
   // zero in every other state, so each new entry into ESPERA gets a full
   // window.
   always_comb begin
      timer_d = '0;
      if (estado_q == ESPERA && estado_d == ESPERA) begin
         timer_d = timer_q + 16'd1;
      end
   end

   // Moore output decode. contaC only comes from PROXIMO, which is reached
   // only when fimC=0, so the address counter never wraps past 15.
   always_comb begin
      zeraC     = 1'b0;
      contaC    = 1'b0;
      zeraR     = 1'b0;
      registraR = 1'b0;
      pronto    = 1'b0;
      acertou   = 1'b0;
      errou     = 1'b0;
      timeout   = 1'b0;
      case (estado_q)
         PREPARACAO: begin
            zeraC = 1'b1;
            zeraR = 1'b1;
         end
         REGISTRA: begin
            registraR = 1'b1;
         end
         PROXIMO: begin
            contaC = 1'b1;
         end
         FIM_ACERTO: begin
            pronto  = 1'b1;
            acertou = 1'b1;
         end
         FIM_ERRO: begin
            pronto = 1'b1;
            errou  = 1'b1;
         end
         FIM_TIMEOUT: begin
            pronto  = 1'b1;
            timeout = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// ============================================================================
// tb_unidade_controle
// ----------------------------------------------------------------------------
// Directed bench for unidade_controle with TIMEOUT=8. Inputs change 1 ns
// after each rising edge and outputs are checked at that same point, well
// clear of the next edge. A negedge monitor checks flag exclusivity and
// control-pair exclusivity on every cycle once reset has been applied.
// Output vector order used below:
//   {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
// ============================================================================
module tb_unidade_controle;

   localparam logic [3:0] S_INICIAL     = 4'b0000;
   localparam logic [3:0] S_PREPARACAO  = 4'b0001;
   localparam logic [3:0] S_ESPERA      = 4'b0010;
   localparam logic [3:0] S_REGISTRA    = 4'b0100;
   localparam logic [3:0] S_COMPARACAO  = 4'b0101;
   localparam logic [3:0] S_PROXIMO     = 4'b0110;
   localparam logic [3:0] S_FIM_ACERTO  = 4'b1010;
   localparam logic [3:0] S_FIM_ERRO    = 4'b1110;
   localparam logic [3:0] S_FIM_TIMEOUT = 4'b1101;

   localparam logic [7:0] O_NONE     = 8'b0000_0000;
   localparam logic [7:0] O_PREP     = 8'b1010_0000;
   localparam logic [7:0] O_REGISTRA = 8'b0001_0000;
   localparam logic [7:0] O_PROXIMO  = 8'b0100_0000;
   localparam logic [7:0] O_ACERTO   = 8'b0000_1100;
   localparam logic [7:0] O_ERRO     = 8'b0000_1010;
   localparam logic [7:0] O_TIMEOUT  = 8'b0000_1001;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic       jogada;
   logic       igual;
   logic       fimC;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic [3:0] db_estado;

   int checks     = 0;
   int errors     = 0;
   int contaCount = 0;
   bit monitorOn  = 1'b0;

   unidade_controle #(
      .TIMEOUT(8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .iniciar  (iniciar),
      .jogada   (jogada),
      .igual    (igual),
      .fimC     (fimC),
      .zeraC    (zeraC),
      .contaC   (contaC),
      .zeraR    (zeraR),
      .registraR(registraR),
      .pronto   (pronto),
      .acertou  (acertou),
      .errou    (errou),
      .timeout  (timeout),
      .db_estado(db_estado)
   );

   // 10 ns clock period.
   always #5 clock = ~clock;

   // Count counter-advance pulses seen by the datapath.
   always @(posedge clock) begin
      if (contaC === 1'b1) contaCount++;
   end

   // Every-cycle invariants: at most one outcome flag, each implying pronto,
   // and never clear+count or clear+load together.
   always @(negedge clock) begin
      if (monitorOn) begin
         checks++;
         assert (({1'b0, acertou} + {1'b0, errou} + {1'b0, timeout}) <= 2'd1 &&
                 (!acertou || pronto) && (!errou || pronto) && (!timeout || pronto))
         else begin
            errors++;
            $error("[TB] FAIL flags observed=%b%b%b%b required=onehot0 implying pronto",
                   pronto, acertou, errou, timeout);
         end
         checks++;
         assert (!(zeraC && contaC) && !(zeraR && registraR))
         else begin
            errors++;
            $error("[TB] FAIL ctrlpairs observed=%b%b%b%b required=no clear+count/load",
                   zeraC, contaC, zeraR, registraR);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [3:0] expState,
                             input logic [7:0] expOuts);
      checkOutput({tag, "_estado"}, {12'd0, db_estado}, {12'd0, expState});
      checkOutput({tag, "_outs"},
                  {8'd0, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout},
                  {8'd0, expOuts});
   endtask

   // One play from ESPERA: pulse jogada, present the comparator result in
   // REGISTRA so it is valid in COMPARACAO, then check where it lands. A
   // PROXIMO landing is followed back into ESPERA.
   task automatic applyStimulus(input string tag, input logic igualV, input logic fimV,
                                input logic [3:0] expState, input logic [7:0] expOuts);
      jogada = 1'b1;
      tick();
      checkState({tag, "_reg"}, S_REGISTRA, O_REGISTRA);
      jogada = 1'b0;
      igual  = igualV;
      fimC   = fimV;
      tick();
      checkState({tag, "_cmp"}, S_COMPARACAO, O_NONE);
      tick();
      checkState({tag, "_res"}, expState, expOuts);
      igual = 1'b0;
      fimC  = 1'b0;
      if (expState == S_PROXIMO) begin
         tick();
         checkState({tag, "_esp"}, S_ESPERA, O_NONE);
      end
   endtask

   task automatic startRound(input string tag);
      iniciar = 1'b1;
      tick();
      checkState({tag, "_prep"}, S_PREPARACAO, O_PREP);
      iniciar = 1'b0;
      tick();
      checkState({tag, "_esp"}, S_ESPERA, O_NONE);
   endtask

   initial begin
      reset   = 1'b1;
      iniciar = 1'b0;
      jogada  = 1'b0;
      igual   = 1'b0;
      fimC    = 1'b0;

      // Reset state
      tick();
      tick();
      reset     = 1'b0;
      monitorOn = 1'b1;
      checkState("reset", S_INICIAL, O_NONE);
      checkOutput("reset_timer", dut.timer_q, 16'd0);
      tick();
      checkState("idle_hold", S_INICIAL, O_NONE);

      // Full correct round: 16 matching plays, fimC on the last one
      $display("[TB] full correct round");
      startRound("r1");
      contaCount = 0;
      for (int i = 0; i < 16; i++) begin
         // Idle a few cycles in ESPERA, below the timeout window
         for (int w = 0; w < (i % 4); w++) begin
            iniciar = (i == 2);
            tick();
            checkState($sformatf("r1_wait%0d", i), S_ESPERA, O_NONE);
         end
         iniciar = 1'b0;
         if (i < 15)
            applyStimulus($sformatf("r1_play%0d", i), 1'b1, 1'b0, S_PROXIMO, O_PROXIMO);
         else
            applyStimulus("r1_play15", 1'b1, 1'b1, S_FIM_ACERTO, O_ACERTO);
      end
      checkOutput("r1_contaC_pulses", 16'(contaCount), 16'd15);
      tick();
      checkState("r1_hold", S_FIM_ACERTO, O_ACERTO);

      // Restart from FIM_ACERTO, then err on the 3rd play
      $display("[TB] restart and error round");
      startRound("r2");
      contaCount = 0;
      applyStimulus("r2_play0", 1'b1, 1'b0, S_PROXIMO, O_PROXIMO);
      applyStimulus("r2_play1", 1'b1, 1'b0, S_PROXIMO, O_PROXIMO);
      applyStimulus("r2_play2", 1'b0, 1'b0, S_FIM_ERRO, O_ERRO);
      checkOutput("r2_contaC_pulses", 16'(contaCount), 16'd2);
      tick();
      checkState("r2_hold", S_FIM_ERRO, O_ERRO);

      // Reset in FIM_ERRO together with iniciar
      reset   = 1'b1;
      iniciar = 1'b1;
      tick();
      reset   = 1'b0;
      iniciar = 1'b0;
      checkState("rst_fimerro", S_INICIAL, O_NONE);
      checkOutput("rst_fimerro_timer", dut.timer_q, 16'd0);

      // Timeout: no play for 8 ESPERA cycles
      $display("[TB] timeout cases");
      startRound("t1");
      for (int c = 2; c <= 8; c++) begin
         tick();
         checkState($sformatf("t1_esp%0d", c), S_ESPERA, O_NONE);
      end
      tick();
      checkState("t1_timeout", S_FIM_TIMEOUT, O_TIMEOUT);
      tick();
      checkState("t1_hold", S_FIM_TIMEOUT, O_TIMEOUT);

      // Play in the 8th ESPERA cycle wins over the timeout
      startRound("t2");
      for (int c = 2; c <= 8; c++) begin
         tick();
      end
      checkState("t2_esp8", S_ESPERA, O_NONE);
      applyStimulus("t2_play0", 1'b1, 1'b0, S_PROXIMO, O_PROXIMO);

      // Fresh window after re-entering ESPERA: 8 more cycles to timeout
      for (int c = 2; c <= 8; c++) begin
         tick();
      end
      checkState("t2_esp8b", S_ESPERA, O_NONE);
      tick();
      checkState("t2_timeout", S_FIM_TIMEOUT, O_TIMEOUT);

      // Reset in COMPARACAO with iniciar high and a mismatch pending
      $display("[TB] reset mid-round");
      startRound("r3");
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
      tick();
      checkState("r3_cmp", S_COMPARACAO, O_NONE);
      reset   = 1'b1;
      iniciar = 1'b1;
      igual   = 1'b0;
      tick();
      reset   = 1'b0;
      iniciar = 1'b0;
      checkState("rst_cmp", S_INICIAL, O_NONE);
      checkOutput("rst_cmp_timer", dut.timer_q, 16'd0);
      tick();
      checkState("rst_cmp_hold", S_INICIAL, O_NONE);

      monitorOn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
